// File: rtl/anabellek_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anabellek_pkg : shared encodings for the main-memory arbiter          |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package anabellek_pkg;

  localparam logic [1:0] BOS   = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] ONAY  = 2'd2;
  localparam logic [1:0] BEKLE = 2'd3;

  localparam logic ISTEKCI_VO = 1'b0;
  localparam logic ISTEKCI_BO = 1'b1;

  localparam logic [31:0] BLOK_HIZALAMA = 32'hFFFF_FFF0;

  localparam int ZAMAN_ASIMI_VARSAYILAN = 1024;

  function automatic logic [31:0] blok_hizala(input logic [31:0] i_adres);
    return i_adres & BLOK_HIZALAMA;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anabellek_hakem_secici.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anabellek_hakem_secici : two-way round-robin / fixed-priority picker  |
// | Revision               : 1.0                                          |
// +----------------------------------------------------------------------+
module anabellek_hakem_secici
  import anabellek_pkg::*;
#(
  parameter bit VO_ONCELIKLI = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vo_istek,
  input  logic i_bo_istek,
  input  logic i_ver,
  output logic o_gecerli,
  output logic o_kazanan
);

  // Requester that wins the next tie; flips away from whoever is granted.
  logic r_oncelik;
  logic w_esitlik_kazanan;

  always_comb begin
    w_esitlik_kazanan = VO_ONCELIKLI ? ISTEKCI_VO : r_oncelik;
    o_gecerli         = i_vo_istek | i_bo_istek;
    if (i_vo_istek && i_bo_istek) begin
      o_kazanan = w_esitlik_kazanan;
    end else if (i_vo_istek) begin
      o_kazanan = ISTEKCI_VO;
    end else begin
      o_kazanan = ISTEKCI_BO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oncelik <= ISTEKCI_VO;
    end else if (i_ver && o_gecerli) begin
      r_oncelik <= ~o_kazanan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/anabellek_hakem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anabellek_hakem : data/instruction cache arbiter for the memory ctrl  |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module anabellek_hakem
  import anabellek_pkg::*;
#(
  parameter bit VO_ONCELIKLI = 1'b0,
  parameter int ZAMAN_ASIMI  = ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         vo_istek_i,
  input  logic         vo_yaz_i,
  input  logic [31:0]  vo_adres_i,
  input  logic [127:0] vo_yaz_veri_obegi_i,
  output logic         vo_kabul_o,
  output logic         vo_tamam_o,
  input  logic         bo_istek_i,
  input  logic [31:0]  bo_adres_i,
  output logic         bo_kabul_o,
  output logic         bo_tamam_o,
  output logic [127:0] okunan_veri_obegi_o,
  input  logic         anabellek_musait_i,
  input  logic         okunan_veri_obegi_hazir_i,
  input  logic [127:0] okunan_veri_obegi_i,
  output logic         anabellege_istek_o,
  output logic         oku_o,
  output logic         yaz_o,
  output logic [31:0]  oku_adres_o,
  output logic [31:0]  yaz_adres_o,
  output logic [127:0] yaz_veri_obegi_o,
  output logic         mesgul_o,
  output logic         hata_o
);

  localparam int                 c_sayac_g  = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [c_sayac_g-1:0] c_zaman_son = c_sayac_g'(ZAMAN_ASIMI);

  logic [1:0]           r_durum;
  logic [1:0]           w_durum_sonraki;
  logic                 r_id;
  logic                 r_yaz;
  logic [31:0]          r_adres;
  logic [127:0]         r_yveri;
  logic [127:0]         r_okunan;
  logic                 r_veri_alindi;
  logic [c_sayac_g-1:0] r_sayac;
  logic [c_sayac_g-1:0] w_sayac_art;

  logic         w_gecerli;
  logic         w_kazanan;
  logic         w_ver;
  logic         w_bitti;
  logic         w_zaman_doldu;
  logic         w_hazir_gecerli;
  logic         w_k_id;
  logic         w_k_yaz;
  logic [31:0]  w_k_adres;
  logic [127:0] w_k_yveri;
  logic         w_aktif;
  logic         w_istek_s;
  logic         w_oku_s;
  logic         w_yaz_s;
  logic [127:0] w_okunan_s;

  anabellek_hakem_secici #(
    .VO_ONCELIKLI (VO_ONCELIKLI)
  ) u_secici (
    .clk        (clk_i),
    .rst        (rst_i),
    .i_vo_istek (vo_istek_i),
    .i_bo_istek (bo_istek_i),
    .i_ver      (w_ver),
    .o_gecerli  (w_gecerli),
    .o_kazanan  (w_kazanan)
  );

  assign w_ver           = (r_durum == BOS) && anabellek_musait_i && w_gecerli;
  assign w_sayac_art     = r_sayac + 1'b1;
  assign w_hazir_gecerli = (r_durum == BEKLE) && !r_yaz && okunan_veri_obegi_hazir_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
    end else begin
      r_durum <= w_durum_sonraki;
    end
  end

  always_comb begin
    w_durum_sonraki = r_durum;
    w_bitti         = 1'b0;
    w_zaman_doldu   = 1'b0;
    case (r_durum)
      BOS: begin
        if (w_ver) w_durum_sonraki = ISTEK;
      end
      ISTEK: w_durum_sonraki = ONAY;
      ONAY: begin
        if (!anabellek_musait_i) begin
          w_durum_sonraki = BEKLE;
        end else if (w_sayac_art == c_zaman_son) begin
          w_durum_sonraki = BOS;
          w_zaman_doldu   = 1'b1;
        end
      end
      default: begin
        // A read only completes once its block has been seen.
        if (anabellek_musait_i && (r_yaz || r_veri_alindi || okunan_veri_obegi_hazir_i)) begin
          w_durum_sonraki = BOS;
          w_bitti         = 1'b1;
        end else if (w_sayac_art == c_zaman_son) begin
          w_durum_sonraki = BOS;
          w_zaman_doldu   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_k_id     = w_ver ? w_kazanan : r_id;
    w_k_yaz    = w_ver ? ((w_kazanan == ISTEKCI_VO) && vo_yaz_i) : r_yaz;
    w_k_adres  = w_ver ? blok_hizala((w_kazanan == ISTEKCI_VO) ? vo_adres_i : bo_adres_i)
                       : r_adres;
    w_k_yveri  = w_ver ? (((w_kazanan == ISTEKCI_VO) && vo_yaz_i) ? vo_yaz_veri_obegi_i : '0)
                       : r_yveri;
    w_aktif    = (w_durum_sonraki != BOS);
    w_istek_s  = (w_durum_sonraki == ISTEK);
    w_oku_s    = w_aktif && !w_k_yaz;
    w_yaz_s    = w_aktif && w_k_yaz;
    w_okunan_s = '0;
    if (w_bitti && !r_yaz) begin
      w_okunan_s = w_hazir_gecerli ? okunan_veri_obegi_i : r_okunan;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      anabellege_istek_o  <= 1'b0;
      vo_kabul_o          <= 1'b0;
      bo_kabul_o          <= 1'b0;
      vo_tamam_o          <= 1'b0;
      bo_tamam_o          <= 1'b0;
      oku_o               <= 1'b0;
      yaz_o               <= 1'b0;
      oku_adres_o         <= '0;
      yaz_adres_o         <= '0;
      yaz_veri_obegi_o    <= '0;
      okunan_veri_obegi_o <= '0;
      mesgul_o            <= 1'b0;
    end else begin
      anabellege_istek_o  <= w_istek_s;
      vo_kabul_o          <= w_istek_s && (w_k_id == ISTEKCI_VO);
      bo_kabul_o          <= w_istek_s && (w_k_id == ISTEKCI_BO);
      vo_tamam_o          <= w_bitti && (r_id == ISTEKCI_VO);
      bo_tamam_o          <= w_bitti && (r_id == ISTEKCI_BO);
      oku_o               <= w_oku_s;
      yaz_o               <= w_yaz_s;
      oku_adres_o         <= w_oku_s ? w_k_adres : '0;
      yaz_adres_o         <= w_yaz_s ? w_k_adres : '0;
      yaz_veri_obegi_o    <= w_yaz_s ? w_k_yveri : '0;
      okunan_veri_obegi_o <= w_okunan_s;
      mesgul_o            <= w_aktif;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id          <= ISTEKCI_VO;
      r_yaz         <= 1'b0;
      r_adres       <= '0;
      r_yveri       <= '0;
      r_okunan      <= '0;
      r_veri_alindi <= 1'b0;
      r_sayac       <= '0;
      hata_o        <= 1'b0;
    end else begin
      r_id    <= w_k_id;
      r_yaz   <= w_k_yaz;
      r_adres <= w_k_adres;
      r_yveri <= w_k_yveri;
      if (w_ver) begin
        r_veri_alindi <= 1'b0;
      end else if (w_hazir_gecerli) begin
        r_veri_alindi <= 1'b1;
        r_okunan      <= okunan_veri_obegi_i;
      end
      if (r_durum == ISTEK) begin
        r_sayac <= '0;
      end else if ((r_durum == ONAY) || (r_durum == BEKLE)) begin
        r_sayac <= w_sayac_art;
      end
      if (w_zaman_doldu) begin
        hata_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anabellek_hakem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_anabellek_hakem : directed vector bench for anabellek_hakem        |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_anabellek_hakem;

  logic         clk = 1'b0;
  logic         rst;
  logic         vo_istek, vo_yaz, bo_istek, musait, hazir;
  logic [31:0]  vo_adres, bo_adres;
  logic [127:0] vo_yveri, rveri;

  logic         d0_vo_kabul, d0_vo_tamam, d0_bo_kabul, d0_bo_tamam;
  logic         d0_istek, d0_oku, d0_yaz, d0_mesgul, d0_hata;
  logic [31:0]  d0_oku_adres, d0_yaz_adres;
  logic [127:0] d0_yveri, d0_okunan;

  logic         d1_vo_kabul, d1_vo_tamam, d1_bo_kabul, d1_bo_tamam;
  logic         d1_istek, d1_oku, d1_yaz, d1_mesgul, d1_hata;
  logic [31:0]  d1_oku_adres, d1_yaz_adres;
  logic [127:0] d1_yveri, d1_okunan;

  always #5 clk = ~clk;

  anabellek_hakem #(.VO_ONCELIKLI(1'b0), .ZAMAN_ASIMI(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .vo_istek_i(vo_istek), .vo_yaz_i(vo_yaz), .vo_adres_i(vo_adres),
    .vo_yaz_veri_obegi_i(vo_yveri), .vo_kabul_o(d0_vo_kabul), .vo_tamam_o(d0_vo_tamam),
    .bo_istek_i(bo_istek), .bo_adres_i(bo_adres), .bo_kabul_o(d0_bo_kabul),
    .bo_tamam_o(d0_bo_tamam), .okunan_veri_obegi_o(d0_okunan),
    .anabellek_musait_i(musait), .okunan_veri_obegi_hazir_i(hazir),
    .okunan_veri_obegi_i(rveri), .anabellege_istek_o(d0_istek),
    .oku_o(d0_oku), .yaz_o(d0_yaz), .oku_adres_o(d0_oku_adres),
    .yaz_adres_o(d0_yaz_adres), .yaz_veri_obegi_o(d0_yveri),
    .mesgul_o(d0_mesgul), .hata_o(d0_hata)
  );

  anabellek_hakem #(.VO_ONCELIKLI(1'b1), .ZAMAN_ASIMI(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .vo_istek_i(vo_istek), .vo_yaz_i(vo_yaz), .vo_adres_i(vo_adres),
    .vo_yaz_veri_obegi_i(vo_yveri), .vo_kabul_o(d1_vo_kabul), .vo_tamam_o(d1_vo_tamam),
    .bo_istek_i(bo_istek), .bo_adres_i(bo_adres), .bo_kabul_o(d1_bo_kabul),
    .bo_tamam_o(d1_bo_tamam), .okunan_veri_obegi_o(d1_okunan),
    .anabellek_musait_i(musait), .okunan_veri_obegi_hazir_i(hazir),
    .okunan_veri_obegi_i(rveri), .anabellege_istek_o(d1_istek),
    .oku_o(d1_oku), .yaz_o(d1_yaz), .oku_adres_o(d1_oku_adres),
    .yaz_adres_o(d1_yaz_adres), .yaz_veri_obegi_o(d1_yveri),
    .mesgul_o(d1_mesgul), .hata_o(d1_hata)
  );

  typedef struct {
    logic         vo_i;
    logic         bo_i;
    logic         vo_yaz;
    logic [31:0]  vo_adr;
    logic [31:0]  bo_adr;
    logic [127:0] wblk;
    logic [127:0] rblk;
    logic         kaz0_vo;
    logic         kaz1_vo;
    logic [31:0]  exp_adr;
  } vek_t;

  vek_t tbl [7];
  int   n_top = 0;
  int   n_gec = 0;

  task automatic chk(input string ad, input logic [127:0] gercek, input logic [127:0] bekl);
    n_top++;
    if (gercek === bekl) n_gec++;
    else $display("FAIL %s: got %h expected %h", ad, gercek, bekl);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_row(input vek_t v);
    vo_istek = v.vo_i;
    bo_istek = v.bo_i;
    vo_yaz   = v.vo_yaz;
    vo_adres = v.vo_adr;
    bo_adres = v.bo_adr;
    vo_yveri = v.wblk;
  endtask

  initial begin
    logic         wy;
    logic         erken;
    logic         tamam_var;
    logic [127:0] e_adr;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 128'h0,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 1'b0, 32'h0000_1230};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h2000_000F, 128'h0,
               128'h1111_0000_2222_0000_3333_0000_4444_0000, 1'b1, 1'b1, 32'h0000_0100};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h2000_0014, 128'h0,
               128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 1'b0, 1'b1, 32'h2000_0010};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_030C, 32'h2000_0020, 128'h0,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b1, 32'h0000_0300};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h2000_003F, 128'h0,
               128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, 1'b0, 1'b1, 32'h2000_0030};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 128'h4444_3333_2222_1111,
               128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 1'b1, 1'b1, 32'h0000_0080};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 128'h0,
               128'h0F0F_0F0F_F0F0_F0F0_AAAA_5555_1234_5678, 1'b0, 1'b0, 32'hFFFF_FFF0};

    rst = 1'b1; musait = 1'b1; hazir = 1'b0; rveri = '0;
    vo_istek = 1'b0; vo_yaz = 1'b0; vo_adres = '0; vo_yveri = '0;
    bo_istek = 1'b0; bo_adres = '0;
    repeat (2) tick();
    chk("reset kontrol", {d0_istek, d0_oku, d0_yaz, d0_mesgul, d0_hata,
                          d0_vo_kabul, d0_bo_kabul, d0_vo_tamam, d0_bo_tamam}, '0);
    chk("reset adres", {d0_oku_adres, d0_yaz_adres}, '0);
    chk("reset yveri", d0_yveri, '0);
    chk("reset okunan", d0_okunan, '0);

    rst = 1'b0;
    set_row(tbl[0]);
    for (int i = 0; i < 7; i++) begin
      wy    = tbl[i].vo_yaz && tbl[i].kaz0_vo;
      e_adr = wy ? {64'h0, tbl[i].exp_adr} : {64'h0, tbl[i].exp_adr, 32'h0};
      tick();
      chk($sformatf("r%0d istek", i), d0_istek, 1'b1);
      chk($sformatf("r%0d kabul", i), {d0_vo_kabul, d0_bo_kabul}, tbl[i].kaz0_vo ? 2'b10 : 2'b01);
      chk($sformatf("r%0d kabul oncelikli", i), {d1_vo_kabul, d1_bo_kabul},
          tbl[i].kaz1_vo ? 2'b10 : 2'b01);
      chk($sformatf("r%0d tamam tek", i), {d0_vo_tamam, d0_bo_tamam}, 2'b00);
      chk($sformatf("r%0d okuyaz", i), {d0_oku, d0_yaz}, wy ? 2'b01 : 2'b10);
      chk($sformatf("r%0d adres", i), {d0_oku_adres, d0_yaz_adres}, e_adr);
      chk($sformatf("r%0d yveri", i), d0_yveri, wy ? tbl[i].wblk : 128'h0);
      if (tbl[i].kaz0_vo) begin
        vo_istek = 1'b0; vo_yaz = 1'b0; vo_adres = 32'hDEAD_BEEF; vo_yveri = '1;
      end else begin
        bo_istek = 1'b0;
      end
      tick();
      chk($sformatf("r%0d istek darbe", i), {d0_istek, d0_vo_kabul, d0_bo_kabul}, 3'b000);
      musait = 1'b0;
      for (int b = 0; b < 4; b++) begin
        tick();
        chk($sformatf("r%0d b%0d tut adres", i, b), {d0_oku_adres, d0_yaz_adres}, e_adr);
        chk($sformatf("r%0d b%0d tut yveri", i, b), d0_yveri, wy ? tbl[i].wblk : 128'h0);
        chk($sformatf("r%0d b%0d tut durum", i, b),
            {d0_oku, d0_yaz, d0_mesgul, d0_vo_tamam, d0_bo_tamam}, {~wy, wy, 3'b100});
      end
      musait = 1'b1; hazir = 1'b1; rveri = tbl[i].rblk;
      tick();
      chk($sformatf("r%0d tamam", i), {d0_vo_tamam, d0_bo_tamam}, tbl[i].kaz0_vo ? 2'b10 : 2'b01);
      chk($sformatf("r%0d okunan", i), d0_okunan, wy ? 128'h0 : tbl[i].rblk);
      chk($sformatf("r%0d bos", i), {d0_mesgul, d0_oku, d0_yaz, d0_istek}, 4'b0000);
      hazir = 1'b0; rveri = '1;
      if (i < 6) set_row(tbl[i + 1]);
      else begin vo_istek = 1'b0; bo_istek = 1'b0; end
    end
    tick();

    // Controller busy right after reset, then a transaction that never finishes.
    rst = 1'b1; musait = 1'b0;
    tick();
    rst = 1'b0; bo_istek = 1'b1; bo_adres = 32'h0000_0ABC;
    tick();
    chk("musait bekle 1", {d0_istek, d0_mesgul, d0_bo_kabul}, 3'b000);
    tick();
    chk("musait bekle 2", {d0_istek, d0_mesgul, d0_bo_kabul}, 3'b000);
    musait = 1'b1;
    tick();
    chk("musait sonra", {d0_istek, d0_bo_kabul, d0_oku_adres}, {2'b11, 32'h0000_0AB0});
    bo_istek = 1'b0;
    erken = 1'b0; tamam_var = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) musait = 1'b0;
      erken     = erken | d0_hata;
      tamam_var = tamam_var | d0_vo_tamam | d0_bo_tamam;
    end
    chk("zaman erken", erken, 1'b0);
    tick();
    chk("zaman hata", {d0_hata, d0_mesgul, d0_oku}, 3'b100);
    musait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tamam_var = tamam_var | d0_vo_tamam | d0_bo_tamam;
    end
    chk("hata kalici", {d0_hata, d0_mesgul}, 2'b10);
    chk("zaman tamam yok", tamam_var, 1'b0);

    // Reset during BEKLE of a data-cache read, then a fresh instruction read.
    vo_istek = 1'b1; vo_yaz = 1'b0; vo_adres = 32'h0000_0500;
    tick();
    chk("kesme kabul", {d0_vo_kabul, d0_oku_adres}, {1'b1, 32'h0000_0500});
    vo_istek = 1'b0;
    tick();
    musait = 1'b0;
    tick();
    chk("kesme bekle", {d0_mesgul, d0_istek}, 2'b10);
    rst = 1'b1; musait = 1'b1;
    tick();
    chk("kesme sifir", {d0_istek, d0_oku, d0_yaz, d0_mesgul, d0_hata,
                        d0_vo_kabul, d0_bo_kabul, d0_vo_tamam, d0_bo_tamam}, '0);
    chk("kesme adres", {d0_oku_adres, d0_yaz_adres}, '0);
    rst = 1'b0; bo_istek = 1'b1; bo_adres = 32'h0000_7778;
    tick();
    chk("taze kabul", {d0_bo_kabul, d0_vo_kabul, d0_oku_adres}, {2'b10, 32'h0000_7770});
    bo_istek = 1'b0;
    tick();
    musait = 1'b0;
    tick();
    musait = 1'b1; hazir = 1'b1; rveri = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    tick();
    chk("taze tamam", {d0_bo_tamam, d0_vo_tamam}, 2'b10);
    chk("taze okunan", d0_okunan, 128'h7777_6666_5555_4444_3333_2222_1111_0000);
    hazir = 1'b0;
    tick();
    chk("taze tamam bitti", {d0_bo_tamam, d0_mesgul, d0_okunan}, '0);

    $display("%0d/%0d checks passed", n_gec, n_top);
    $finish;
  end

endmodule
`default_nettype wire
